// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front-end: sequential PC generation, req/ack fetch from a
// variable-latency instruction memory, and a DEPTH-entry prefetch FIFO that
// presents {instr, pc} to the datapath under valid/ready.
// A taken branch/jump (redirect) flushes the FIFO; an unacked in-flight
// request is completed and its word thrown away (DISCARD state).
// Optional build macro FETCH_FLUSH_STATS_EN adds saturating flush/discard
// counters as extra output ports.
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_FLUSH_STATS_EN
    ,
    output logic [15:0] flush_count,
    output logic [15:0] discard_count
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        S_FETCH   = 1'b0,
        S_DISCARD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [31:0]        fifo_instr_q [DEPTH];
    logic [31:0]        fifo_pc_q    [DEPTH];

    logic               ack;
    logic               pop;
    logic               push;
    logic [31:0]        redirect_pc_al;
    logic               unused_redirect_lsbs;

    // Low address bits of the redirect target are architecturally ignored.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_pc_al       = {redirect_pc[31:2], 2'b00};

    assign ack         = mem_req_q & mem_ack;
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready;

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;

    // Next-state logic: FSM, request issue with slot reservation, FIFO pointers.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        push       = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    // Flush everything; any word acked on this edge is dropped.
                    rd_ptr_d   = '0;
                    wr_ptr_d   = '0;
                    count_d    = '0;
                    fetch_pc_d = redirect_pc_al;
                    if (mem_req_q && !mem_ack) begin
                        // Keep the old handshake alive and throw its data away later.
                        state_d = S_DISCARD;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = redirect_pc_al;
                    end
                end else begin
                    push = ack;
                    if (push) begin
                        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                        fetch_pc_d = mem_addr_q + 32'd4;
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
                    if (mem_req_q && !mem_ack) begin
                        // Request stays stable until accepted.
                        mem_req_d  = 1'b1;
                        mem_addr_d = mem_addr_q;
                    end else begin
                        // A new request reserves one slot, so it needs room for it.
                        mem_req_d  = (count_d < CNT_W'(DEPTH));
                        mem_addr_d = fetch_pc_d;
                    end
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                end
                if (ack) begin
                    // Stale word dropped; one idle cycle before fetching the new PC.
                    state_d    = S_FETCH;
                    mem_req_d  = 1'b0;
                    mem_addr_d = fetch_pc_d;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Control and address state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage: validity is tracked by count_q, so entries need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= mem_rdata;
            fifo_pc_q[wr_ptr_q]    <= mem_addr_q;
        end
    end

`ifdef FETCH_FLUSH_STATS_EN
    logic        drop;
    logic [15:0] flush_count_q, flush_count_d;
    logic [15:0] discard_count_q, discard_count_d;

    assign flush_count   = flush_count_q;
    assign discard_count = discard_count_q;

    // Saturating event counters for redirects and dropped acked words.
    always_comb begin
        drop            = ack & (redirect | (state_q == S_DISCARD));
        flush_count_d   = flush_count_q;
        discard_count_d = discard_count_q;
        if (redirect && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
        if (drop && (discard_count_q != 16'hFFFF)) begin
            discard_count_d = discard_count_q + 16'd1;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_count_q   <= 16'h0;
            discard_count_q <= 16'h0;
        end else begin
            flush_count_q   <= flush_count_d;
            discard_count_q <= discard_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed, table-driven bench for fetch_prefetch_unit (DEPTH=4, RESET_PC=0).
// Each table row is one clock: inputs applied at the falling edge, outputs
// compared 1 time unit after the following rising edge.
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef FETCH_FLUSH_STATS_EN
    logic [15:0] flush_count;
    logic [15:0] discard_count;
`endif

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vq[$];
    int   n_total;
    int   n_pass;

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    fetch_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
`ifdef FETCH_FLUSH_STATS_EN
        .flush_count   (flush_count),
        .discard_count (discard_count),
`endif
        .instr_ready   (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rd, input logic [31:0] rpc,
                       input logic a, input logic y, input logic eq,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.redir = rd; v.rpc = rpc; v.ack = a; v.rdy = y;
        v.e_req = eq; v.e_addr = ea; v.e_vld = ev; v.e_pc = ep;
        vq.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_vld, input logic [31:0] e_pc);
        check({tag, "_req"},   {31'h0, mem_req},     {31'h0, e_req});
        check({tag, "_addr"},  mem_addr,             e_addr);
        check({tag, "_vld"},   {31'h0, instr_valid}, {31'h0, e_vld});
        check({tag, "_pc"},    instr_pc,             e_pc);
        check({tag, "_instr"}, instr,                e_vld ? mem_fn(e_pc) : 32'h0);
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;

        //   rst   redir rpc            ack   rdy  | req   addr           vld   pc
        // reset state
        add(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0);
        // zero-wait memory, full throughput
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h4,         1'b1, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h8,         1'b1, 32'h4);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hC,         1'b1, 32'h8);
        // reset mid-stream, then fill with instr_ready low
        add(1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h4,         1'b1, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h8,         1'b1, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hC,         1'b1, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h10,        1'b1, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h10,        1'b1, 32'h0);
        // one pop frees one slot -> exactly one request to 0x10
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h10,        1'b1, 32'h4);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h14,        1'b1, 32'h4);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h14,        1'b1, 32'h4);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h14,        1'b1, 32'h8);
        // redirect on same edge as ack and pop, unaligned target
        add(1'b0, 1'b1, 32'h203,       1'b1, 1'b1, 1'b1, 32'h200,       1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h204,       1'b1, 32'h200);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h208,       1'b1, 32'h204);
        // address wrap at the top of memory
        add(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0,         1'b1, 32'hFFFF_FFFC);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h4,         1'b1, 32'h0);
        // slow memory: redirect while request to 0x8 is pending
        add(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h4,         1'b1, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h8,         1'b1, 32'h4);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h8,         1'b0, 32'h0);
        add(1'b0, 1'b1, 32'h100,       1'b0, 1'b1, 1'b1, 32'h8,         1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h100,       1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h100,       1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h104,       1'b1, 32'h100);
        // two redirects in DISCARD: last target wins
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h104,       1'b0, 32'h0);
        add(1'b0, 1'b1, 32'h300,       1'b0, 1'b1, 1'b1, 32'h104,       1'b0, 32'h0);
        add(1'b0, 1'b1, 32'h400,       1'b0, 1'b1, 1'b1, 32'h104,       1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h400,       1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h400,       1'b0, 32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h404,       1'b1, 32'h400);
        // enter DISCARD again for the asynchronous reset sequence below
        add(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h404,       1'b0, 32'h0);
        add(1'b0, 1'b1, 32'h500,       1'b0, 1'b1, 1'b1, 32'h404,       1'b0, 32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst         = vq[i].rst;
            redirect    = vq[i].redir;
            redirect_pc = vq[i].rpc;
            mem_ack     = vq[i].ack;
            instr_ready = vq[i].rdy;
            @(posedge clk);
            #1;
            check_outputs($sformatf("v%0d", i), vq[i].e_req, vq[i].e_addr,
                          vq[i].e_vld, vq[i].e_pc);
        end

`ifdef FETCH_FLUSH_STATS_EN
        // Since the reset at row 22: four redirects, two dropped acked words.
        check("flush_cnt_pre",   {16'h0, flush_count},   32'd4);
        check("discard_cnt_pre", {16'h0, discard_count}, 32'd2);
`endif

        // Asynchronous reset in the middle of DISCARD, away from any clock edge.
        @(negedge clk);
        redirect = 1'b0;
        mem_ack  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_outputs("arst", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef FETCH_FLUSH_STATS_EN
        check("flush_cnt_rst",   {16'h0, flush_count},   32'd0);
        check("discard_cnt_rst", {16'h0, discard_count}, 32'd0);
`endif

        // Restart from RESET_PC after release.
        @(negedge clk);
        rst         = 1'b0;
        mem_ack     = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("restart0", 1'b1, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check_outputs("restart1", 1'b1, 32'h4, 1'b1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction fetch front-end that sits directly upstream of the single-cycle datapath.
- Generates sequential fetch addresses and reads instruction words from a variable-latency instruction memory over a req/ack handshake.
- Buffers fetched words with their PCs in a small FIFO and presents them to the datapath under valid/ready.
- Discards buffered and in-flight instructions when the datapath signals a taken branch or jump.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- redirect  input  1  taken branch/jump from the datapath; sampled on the rising edge.
- redirect_pc  input  32  new fetch address (PCTarget or jalr result); bits [1:0] ignored and forced to 0.
- mem_req  output  1  fetch request to instruction memory (registered).
- mem_addr  output  32  word-aligned fetch address (registered).
- mem_ack  input  1  memory accepts the request; mem_rdata is valid in the same cycle.
- mem_rdata  input  32  instruction word.
- instr_valid  output  1  FIFO head is valid.
- instr  output  32  FIFO head instruction; 0 when instr_valid=0.
- instr_pc  output  32  PC of the FIFO head; 0 when instr_valid=0.
- instr_ready  input  1  datapath consumes the head this cycle.

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC, FIFO empty, state FETCH, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Handshake rules:
  - Transfer occurs on an edge where mem_req=1 and mem_ack=1.
  - Once mem_req is asserted, mem_req and mem_addr hold stable until ack.
  - At most one request is outstanding.
- Slot reservation: an outstanding request owns one FIFO slot. A new request is issued, or mem_req is kept high after an ack, only if (occupancy after this edge) + 1 <= DEPTH.
- Throughput: with zero-wait memory and instr_ready=1, one instruction is delivered per cycle (back-to-back requests with mem_addr advancing by 4).
- Latency: with mem_ack tied high, mem_req rises in the first cycle after rst deasserts. instr_valid rises one cycle later with instr_pc=RESET_PC.
- Pop: occurs when instr_valid and instr_ready are both high. Push and pop in the same edge are both honoured; occupancy is unchanged.
- FIFO:
  - Full means occupancy==DEPTH; no push is possible because of slot reservation.
  - Empty means instr_valid=0; instr_ready is ignored.
  - Read and write pointers wrap modulo DEPTH.
- State FETCH:
  - Normal sequential operation.
  - On ack: push {mem_rdata, mem_addr} and set fetch_pc=mem_addr+4. The address wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- Redirect, no request outstanding, or ack on the same edge:
  - FIFO flushed; any data acked on this edge is dropped; pop ignored.
  - fetch_pc={redirect_pc[31:2],2'b00}.
  - Stay in FETCH. The next request goes to the new address and is asserted in the following cycle.
- Redirect while a request is outstanding and not acked:
  - FIFO flushed; new PC latched.
  - Go to DISCARD. mem_req/mem_addr stay on the old request; the handshake is never abandoned.
- State DISCARD:
  - On ack: data is dropped, mem_req is deasserted for one cycle, and the state returns to FETCH with mem_addr=latched PC.
  - A further redirect while in DISCARD overwrites the latched PC and the state stays DISCARD.
  - instr_valid=0 throughout DISCARD.
- Reset mid-operation: all state is cleared immediately and any outstanding request is abandoned. The memory must tolerate mem_req dropping.

Optional Feature:
- Macro: FETCH_FLUSH_STATS_EN.
- When defined, two output ports are added:
  - flush_count [15:0]: increments on every edge where redirect=1.
  - discard_count [15:0]: increments on every dropped acked word, including the word dropped by a same-edge redirect+ack and the word dropped on the DISCARD ack.
- Both counters saturate at 16'hFFFF and reset to 0.
- When not defined: no extra ports or logic; behaviour is otherwise identical.

Test Plan:
- Reset release, mem_ack=1, instr_ready=1 -> mem_addr 0,4,8,... on consecutive cycles; instr_pc 0,4,8 one cycle behind; instr equals the memory contents.
- instr_ready=0, mem_ack=1, DEPTH=4 -> exactly 4 pushes, then mem_req=0 with instr_pc=0; raising instr_ready for 1 cycle -> exactly one new request, to address 16.
- Memory with 3-cycle ack latency, redirect to 0x100 one cycle after request to 0x8 -> old request held until ack, 0x8 data never appears, next mem_addr=0x100, first instr_pc=0x100.
- Redirect with redirect_pc=0x203 on the same edge as ack and pop -> FIFO empty next cycle, acked word dropped, next mem_addr=0x200.
- Redirect to 0xFFFF_FFFC, zero-wait memory -> instr_pc 0xFFFF_FFFC then 0x0000_0000.
- Assert rst mid-DISCARD -> mem_req=0, instr_valid=0 immediately; after release, fetch restarts at RESET_PC; with FETCH_FLUSH_STATS_EN, both counters read 0.
